// File: rtl/xgmii_crc_check_stats.sv
// xgmii_crc_check_stats: 32-bit XGMII receive FCS checker. It produces a per-frame
// verdict with an error code, can suppress verdicts for PTP frames, and keeps
// saturating good/bad/PTP frame counters.
`timescale 1ns/1ps
module xgmii_crc_check_stats #(
  parameter int unsigned P_MIN_LEN  = 64,
  parameter int unsigned P_MAX_LEN  = 1522,
  parameter int unsigned P_PTP_MODE = 0,
  parameter int unsigned P_CNT_W    = 32
) (
  input  logic               I_312m_clk,
  input  logic               I_global_rst_n,
  input  logic [31:0]        I_xgmii_data,
  input  logic [3:0]         I_xgmii_txc,
  input  logic               I_ptp_flag,
  input  logic               I_cnt_clr,
  output logic               O_crc_ok,
  output logic               O_crc_err,
  output logic               O_crc_compare_signal,
  output logic [2:0]         O_err_code,
  output logic [31:0]        O_crc_out,
  output logic [P_CNT_W-1:0] O_ok_cnt,
  output logic [P_CNT_W-1:0] O_err_cnt,
  output logic [P_CNT_W-1:0] O_ptp_cnt
);
  localparam logic [15:0]        MIN_LEN      = 16'(P_MIN_LEN);
  localparam logic [15:0]        MAX_LEN      = 16'(P_MAX_LEN);
  localparam logic [31:0]        CRC_RESIDUE  = 32'hC704DD7B;
  localparam logic               PTP_SUPPRESS = (P_PTP_MODE != 0);
  localparam logic [P_CNT_W-1:0] CNT_ONE      = P_CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_t;
  state_t state, state_nxt;

  // The running CRC is kept MSB-first; data bits enter LSB first. With this
  // orientation, a good frame leaves the register at CRC_RESIDUE.
  logic [31:0] crc_reg, crc_nxt, crc_fold;
  logic [15:0] len_reg, len_nxt, len_fold;
  logic [16:0] len_sum;
  logic [2:0]  len_inc;
  logic [31:0] fcs_reg, fcs_nxt, fcs_fold;   // newest byte at [31:24]
  logic        ptp_reg, ptp_nxt;
  logic        ctl_found;
  logic [7:0]  ctl_byte;
  logic        is_start, is_sfd;

  logic        s1_vld, s1_vld_nxt, s1_term, s1_term_nxt, s1_ptp;
  logic [2:0]  s1_code, s1_code_nxt;
  logic [31:0] s1_crc, s1_fcs;
  logic [15:0] s1_len;
  logic [2:0]  v_code;
  logic        v_supp;
  logic        ptp_pulse;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign is_start = (I_xgmii_data[7:0] == 8'hFB) && (I_xgmii_txc == 4'b0001);
  assign is_sfd   = (I_xgmii_data == 32'hD5555555) && (I_xgmii_txc == 4'b0000);

  // Fold the data lanes that precede the first control lane into CRC, length and FCS history.
  always_comb begin
    ctl_found = 1'b0;
    ctl_byte  = '0;
    len_inc   = '0;
    crc_fold  = crc_reg;
    fcs_fold  = fcs_reg;
    for (int unsigned k = 0; k < 4; k++) begin
      if (I_xgmii_txc[k] && !ctl_found) begin
        ctl_found = 1'b1;
        ctl_byte  = I_xgmii_data[8*k +: 8];
      end
      if (!ctl_found) begin
        crc_fold = crc_byte(crc_fold, I_xgmii_data[8*k +: 8]);
        fcs_fold = {I_xgmii_data[8*k +: 8], fcs_fold[31:8]};
        len_inc  = len_inc + 3'd1;
      end
    end
    len_sum  = {1'b0, len_reg} + {14'd0, len_inc};
    len_fold = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  // Frame FSM: next state, per-frame accumulators, and launch of the verdict pipeline.
  always_comb begin
    state_nxt   = state;
    crc_nxt     = crc_reg;
    len_nxt     = len_reg;
    fcs_nxt     = fcs_reg;
    ptp_nxt     = ptp_reg;
    s1_vld_nxt  = 1'b0;
    s1_term_nxt = 1'b0;
    s1_code_nxt = 3'd0;
    case (state)
      ST_IDLE: begin
        if (is_start) begin
          state_nxt = ST_PRE;
          ptp_nxt   = I_ptp_flag;
        end
      end
      ST_PRE: begin
        if (is_sfd) begin
          state_nxt = ST_DATA;
          crc_nxt   = '1;
          len_nxt   = '0;
          fcs_nxt   = '0;
        end else begin
          state_nxt   = ST_IDLE;
          s1_vld_nxt  = 1'b1;
          s1_code_nxt = 3'd4;
        end
      end
      ST_DATA: begin
        if (is_start) begin
          // The verdict belongs to the old frame; the start word opens a new one.
          state_nxt   = ST_PRE;
          ptp_nxt     = I_ptp_flag;
          s1_vld_nxt  = 1'b1;
          s1_code_nxt = 3'd6;
        end else if (!ctl_found) begin
          crc_nxt = crc_fold;
          len_nxt = len_fold;
          fcs_nxt = fcs_fold;
        end else if (ctl_byte == 8'hFD) begin
          state_nxt   = ST_IDLE;
          s1_vld_nxt  = 1'b1;
          s1_term_nxt = 1'b1;
        end else begin
          state_nxt   = ST_IDLE;
          s1_vld_nxt  = 1'b1;
          s1_code_nxt = 3'd5;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame state registers.
  always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
    if (!I_global_rst_n) begin
      state   <= ST_IDLE;
      crc_reg <= '0;
      len_reg <= '0;
      fcs_reg <= '0;
      ptp_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      crc_reg <= crc_nxt;
      len_reg <= len_nxt;
      fcs_reg <= fcs_nxt;
      ptp_reg <= ptp_nxt;
    end
  end

  // First verdict stage: a snapshot of the finished frame, independent of the next frame.
  always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
    if (!I_global_rst_n) begin
      s1_vld  <= 1'b0;
      s1_term <= 1'b0;
      s1_code <= '0;
      s1_ptp  <= 1'b0;
      s1_crc  <= '0;
      s1_len  <= '0;
      s1_fcs  <= '0;
    end else begin
      s1_vld  <= s1_vld_nxt;
      s1_term <= s1_term_nxt;
      s1_code <= s1_code_nxt;
      s1_ptp  <= ptp_reg;
      s1_crc  <= crc_fold;
      s1_len  <= len_fold;
      s1_fcs  <= fcs_fold;
    end
  end

  // Classify a terminated frame by priority: oversize, then runt, then CRC.
  always_comb begin
    if (!s1_term)                  v_code = s1_code;
    else if (s1_len > MAX_LEN)     v_code = 3'd3;
    else if (s1_len < MIN_LEN)     v_code = 3'd2;
    else if (s1_crc != CRC_RESIDUE) v_code = 3'd1;
    else                           v_code = 3'd0;
    v_supp = PTP_SUPPRESS && s1_ptp;
  end

  // Verdict outputs, registered so they appear two cycles after the deciding word.
  always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
    if (!I_global_rst_n) begin
      O_crc_compare_signal <= 1'b0;
      O_err_code           <= '0;
      O_crc_ok             <= 1'b0;
      O_crc_err            <= 1'b0;
      O_crc_out            <= '0;
      ptp_pulse            <= 1'b0;
    end else begin
      O_crc_compare_signal <= s1_vld;
      O_err_code           <= (s1_vld && !v_supp) ? v_code : 3'd0;
      O_crc_ok             <= s1_vld && !v_supp && (v_code == 3'd0);
      O_crc_err            <= s1_vld && !v_supp && (v_code != 3'd0);
      ptp_pulse            <= s1_vld && s1_ptp;
      if (s1_vld) O_crc_out <= s1_fcs;
    end
  end

  // Saturating statistics; a clear overrides any increment in the same cycle.
  always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
    if (!I_global_rst_n) begin
      O_ok_cnt  <= '0;
      O_err_cnt <= '0;
      O_ptp_cnt <= '0;
    end else if (I_cnt_clr) begin
      O_ok_cnt  <= '0;
      O_err_cnt <= '0;
      O_ptp_cnt <= '0;
    end else begin
      if (O_crc_ok && (O_ok_cnt != '1))   O_ok_cnt  <= O_ok_cnt + CNT_ONE;
      if (O_crc_err && (O_err_cnt != '1)) O_err_cnt <= O_err_cnt + CNT_ONE;
      if (ptp_pulse && (O_ptp_cnt != '1)) O_ptp_cnt <= O_ptp_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_xgmii_crc_check_stats.sv
// tb_xgmii_crc_check_stats: drives XGMII frames into two checker instances
// (normal PTP mode with 32-bit counters, PTP-suppress mode with 4-bit counters)
// and compares verdicts and counters against a scoreboard.
`timescale 1ns/1ps
module tb_xgmii_crc_check_stats;
  localparam logic [31:0] IDLE_W  = 32'h07070707;
  localparam logic [31:0] START_W = 32'h555555FB;
  localparam logic [31:0] SFD_W   = 32'hD5555555;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data;
  logic [3:0]  txc;
  logic        ptp_flag;
  logic        cnt_clr;

  logic        ok_a, err_a, cmp_a;
  logic [2:0]  code_a;
  logic [31:0] crc_out_a, ok_cnt_a, err_cnt_a, ptp_cnt_a;
  logic        ok_b, err_b, cmp_b;
  logic [2:0]  code_b;
  logic [31:0] crc_out_b;
  logic [3:0]  ok_cnt_b, err_cnt_b, ptp_cnt_b;

  typedef struct {
    int         due;
    logic [2:0] code;
    logic       ptp;
    logic       term;
    logic [31:0] fcs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         m_ok_a = 0, m_err_a = 0, m_ptp_a = 0;
  int         m_ok_b = 0, m_err_b = 0, m_ptp_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xgmii_crc_check_stats #(
    .P_MIN_LEN(64), .P_MAX_LEN(1522), .P_PTP_MODE(0), .P_CNT_W(32)
  ) dut_a (
    .I_312m_clk(clk), .I_global_rst_n(rst_n), .I_xgmii_data(data), .I_xgmii_txc(txc),
    .I_ptp_flag(ptp_flag), .I_cnt_clr(cnt_clr), .O_crc_ok(ok_a), .O_crc_err(err_a),
    .O_crc_compare_signal(cmp_a), .O_err_code(code_a), .O_crc_out(crc_out_a),
    .O_ok_cnt(ok_cnt_a), .O_err_cnt(err_cnt_a), .O_ptp_cnt(ptp_cnt_a)
  );

  xgmii_crc_check_stats #(
    .P_MIN_LEN(64), .P_MAX_LEN(1522), .P_PTP_MODE(1), .P_CNT_W(4)
  ) dut_b (
    .I_312m_clk(clk), .I_global_rst_n(rst_n), .I_xgmii_data(data), .I_xgmii_txc(txc),
    .I_ptp_flag(ptp_flag), .I_cnt_clr(cnt_clr), .O_crc_ok(ok_b), .O_crc_err(err_b),
    .O_crc_compare_signal(cmp_b), .O_err_code(code_b), .O_crc_out(crc_out_b),
    .O_ok_cnt(ok_cnt_b), .O_err_cnt(err_cnt_b), .O_ptp_cnt(ptp_cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC in reflected form, run over the first n bytes of fb, no final xor.
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [2:0] exp_code();
    int n;
    n = fb.size();
    if (n > 1522) return 3'd3;
    if (n < 64) return 3'd2;
    if (crc_ref(n) != 32'hDEBB20E3) return 3'd1;
    return 3'd0;
  endfunction

  task automatic build_good(input int n);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom_range(0, 255)));
    c = ~crc_ref(n - 4);
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] c);
    @(posedge clk);
    #1;
    data = d;
    txc  = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_word(IDLE_W, 4'hF);
  endtask

  task automatic push_exp(input logic [2:0] code, input logic ptp, input logic term,
                          input logic [31:0] fcs);
    exp_t e;
    e.due  = cyc + 2;
    e.code = code;
    e.ptp  = ptp;
    e.term = term;
    e.fcs  = fcs;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic ptp, input logic abort_prev, input logic prev_ptp);
    int          n, i, r;
    logic [31:0] w;
    logic [3:0]  c;
    n = fb.size();
    send_word(START_W, 4'b0001);
    ptp_flag = ptp;
    if (abort_prev) push_exp(3'd6, prev_ptp, 1'b0, '0);
    send_word(SFD_W, 4'h0);
    ptp_flag = 1'b0;
    i = 0;
    while (n - i >= 4) begin
      send_word({fb[i+3], fb[i+2], fb[i+1], fb[i]}, 4'h0);
      i += 4;
    end
    r = n - i;
    w = IDLE_W;
    c = 4'hF;
    for (int k = 0; k < r; k++) begin
      w[8*k +: 8] = fb[i+k];
      c[k] = 1'b0;
    end
    w[8*r +: 8] = 8'hFD;
    send_word(w, c);
    push_exp(exp_code(), ptp, 1'b1, {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
  endtask

  task automatic open_frame(input int n_data);
    send_word(START_W, 4'b0001);
    send_word(SFD_W, 4'h0);
    for (int i = 0; i < n_data; i++) send_word($urandom, 4'h0);
  endtask

  // Monitor: compares outputs on the falling edge and steps the counter model.
  initial begin : monitor
    exp_t e;
    int   iok_a, ierr_a, iptp_a, iok_b, ierr_b, iptp_b;
    logic [2:0] cb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ok_a = 0; m_err_a = 0; m_ptp_a = 0;
        m_ok_b = 0; m_err_b = 0; m_ptp_b = 0;
        check_eq("rst_flags_a", {cmp_a, ok_a, err_a, code_a}, '0);
        check_eq("rst_flags_b", {cmp_b, ok_b, err_b, code_b}, '0);
        check_eq("rst_crc_out_a", crc_out_a, '0);
        check_eq("rst_cnt_a", ok_cnt_a | err_cnt_a | ptp_cnt_a, '0);
        check_eq("rst_cnt_b", {ok_cnt_b, err_cnt_b, ptp_cnt_b}, '0);
      end else begin
        check_eq("ok_cnt_a", ok_cnt_a, m_ok_a);
        check_eq("err_cnt_a", err_cnt_a, m_err_a);
        check_eq("ptp_cnt_a", ptp_cnt_a, m_ptp_a);
        check_eq("ok_cnt_b", ok_cnt_b, m_ok_b);
        check_eq("err_cnt_b", err_cnt_b, m_err_b);
        check_eq("ptp_cnt_b", ptp_cnt_b, m_ptp_b);
        iok_a = 0; ierr_a = 0; iptp_a = 0; iok_b = 0; ierr_b = 0; iptp_b = 0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          check_eq("cmp_a", cmp_a, 1);
          check_eq("code_a", code_a, e.code);
          check_eq("ok_a", ok_a, e.code == 3'd0);
          check_eq("err_a", err_a, e.code != 3'd0);
          cb = e.ptp ? 3'd0 : e.code;
          check_eq("cmp_b", cmp_b, 1);
          check_eq("code_b", code_b, cb);
          check_eq("ok_b", ok_b, !e.ptp && e.code == 3'd0);
          check_eq("err_b", err_b, !e.ptp && e.code != 3'd0);
          if (e.term) begin
            check_eq("crc_out_a", crc_out_a, e.fcs);
            check_eq("crc_out_b", crc_out_b, e.fcs);
          end
          iok_a  = (e.code == 3'd0);
          ierr_a = (e.code != 3'd0);
          iptp_a = e.ptp;
          iok_b  = !e.ptp && e.code == 3'd0;
          ierr_b = !e.ptp && e.code != 3'd0;
          iptp_b = e.ptp;
        end else begin
          check_eq("quiet_a", {cmp_a, ok_a, err_a, code_a}, '0);
          check_eq("quiet_b", {cmp_b, ok_b, err_b, code_b}, '0);
        end
        if (cnt_clr) begin
          m_ok_a = 0; m_err_a = 0; m_ptp_a = 0;
          m_ok_b = 0; m_err_b = 0; m_ptp_b = 0;
        end else begin
          m_ok_a += iok_a; m_err_a += ierr_a; m_ptp_a += iptp_a;
          if (iok_b != 0 && m_ok_b < 15) m_ok_b++;
          if (ierr_b != 0 && m_err_b < 15) m_err_b++;
          if (iptp_b != 0 && m_ptp_b < 15) m_ptp_b++;
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin : stim
    data = IDLE_W; txc = 4'hF; ptp_flag = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Good 64-byte frame, then the same frame with one payload bit flipped.
    build_good(64); send_frame(1'b0, 1'b0, 1'b0); idle(4);
    fb[20] = fb[20] ^ 8'h01; send_frame(1'b0, 1'b0, 1'b0); idle(4);

    // Terminate in each lane, back-to-back.
    for (int n = 64; n <= 67; n++) begin
      build_good(n); send_frame(1'b0, 1'b0, 1'b0);
    end
    idle(4);

    // Length boundaries.
    build_good(60);   send_frame(1'b0, 1'b0, 1'b0); idle(2);
    build_good(63);   send_frame(1'b0, 1'b0, 1'b0); idle(2);
    build_good(1522); send_frame(1'b0, 1'b0, 1'b0); idle(2);
    build_good(1523); send_frame(1'b0, 1'b0, 1'b0); idle(4);

    // Non-start words in IDLE are ignored.
    send_word(START_W, 4'b0011); send_word(32'h070707FD, 4'hF); idle(4);

    // Bad SFD.
    send_word(START_W, 4'b0001); send_word(32'hD5555554, 4'h0);
    push_exp(3'd4, 1'b0, 1'b0, '0); idle(4);

    // Idle inside DATA, and an error char ahead of /T/.
    open_frame(5); send_word(32'h55075555, 4'b0100);
    push_exp(3'd5, 1'b0, 1'b0, '0); idle(4);
    open_frame(5); send_word(32'hFD55FE55, 4'b1010);
    push_exp(3'd5, 1'b0, 1'b0, '0); idle(4);

    // Missing terminate: second start 20 cycles after the first.
    open_frame(18); build_good(64); send_frame(1'b0, 1'b1, 1'b0); idle(4);

    // PTP frame.
    build_good(64); send_frame(1'b1, 1'b0, 1'b0); idle(4);

    // Reset in the middle of DATA.
    open_frame(6);
    @(posedge clk);
    #1;
    rst_n = 1'b0; data = IDLE_W; txc = 4'hF;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Build up counts, then clear in the same cycle as an ok verdict.
    build_good(64); send_frame(1'b0, 1'b0, 1'b0); idle(4);
    build_good(64); send_frame(1'b0, 1'b0, 1'b0);
    send_word(IDLE_W, 4'hF);
    send_word(IDLE_W, 4'hF);
    cnt_clr = 1'b1;
    send_word(IDLE_W, 4'hF);
    cnt_clr = 1'b0;
    idle(4);

    // 17 good frames: the 4-bit counters saturate at 15.
    repeat (17) begin
      build_good(64); send_frame(1'b0, 1'b0, 1'b0);
    end
    idle(6);

    check_eq("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xgmii_crc_check_stats.md
Name: xgmii_crc_check_stats

Overview:
- Parametrised successor to the 32-bit XGMII FCS checker.
- Parses 32-bit XGMII frames, computes CRC-32 over the post-SFD bytes including the FCS, and issues a per-frame verdict with an error code.
- Adds frame length checks, detection of aborted and malformed frames, selectable PTP verdict handling, and saturating statistics counters with clear.
- Sits on the backward path after XGMII receive, ahead of frame accounting.

Parameters:
- P_MIN_LEN, 64: minimum legal frame length in bytes (DA through FCS).
- P_MAX_LEN, 1522: maximum legal frame length in bytes.
- P_PTP_MODE, 0: 0 = PTP frames are checked normally; 1 = PTP frames get no ok/err verdict and are counted only in O_ptp_cnt.
- P_CNT_W, 32: statistics counter width.

Ports:
- I_312m_clk  in  1  system clock.
- I_global_rst_n  in  1  asynchronous reset, active-low.
- I_xgmii_data  in  32  XGMII data; lane0 = [7:0] = first byte in time.
- I_xgmii_txc  in  4  per-lane control flags; bit k qualifies lane k.
- I_ptp_flag  in  1  sampled on the start cycle; marks the frame as PTP.
- I_cnt_clr  in  1  synchronous clear of all counters.
- O_crc_ok  out  1  one-cycle pulse: good frame.
- O_crc_err  out  1  one-cycle pulse: bad frame.
- O_crc_compare_signal  out  1  one-cycle pulse at every frame verdict slot, including PTP-suppressed frames.
- O_err_code  out  3  error code, valid while O_crc_compare_signal is high; 0 otherwise.
- O_crc_out  out  32  received FCS field (last 4 bytes before /T/, lane order); held until the next verdict.
- O_ok_cnt  out  P_CNT_W  count of good frames.
- O_err_cnt  out  P_CNT_W  count of bad frames.
- O_ptp_cnt  out  P_CNT_W  count of PTP frames, counted in both modes.

Behaviour:
- Reset: async and immediate. All outputs, counters, CRC register and length counter go to 0; FSM goes to IDLE. A frame in flight is dropped with no verdict.
- Start word: lane0 = 0xFB with txc = 4'b0001.
- SFD word: the next word must be data 0xD5555555 with txc = 0.
- FSM states IDLE -> PRE -> DATA -> IDLE.
  - IDLE -> PRE on a start word.
  - PRE -> DATA on a correct SFD word. Any other word: abort with code 4.
  - DATA -> IDLE on /T/ (0xFD, txc set) in lane k. Lanes below k are frame data; lanes after k are ignored.
- CRC-32: reflected polynomial 0x04C11DB7, init all ones, over every byte from DA through FCS. Pass when the register residue is 0xC704DD7B.
- Length: 16-bit byte counter, saturating. Counts DA through FCS.
- Error codes:
  - 0 = ok
  - 1 = CRC mismatch
  - 2 = runt (< P_MIN_LEN)
  - 3 = oversize (> P_MAX_LEN)
  - 4 = bad preamble/SFD
  - 5 = control character other than /T/ inside DATA (including idle 0x07 and error 0xFE)
  - 6 = start word while in DATA (missing terminate)
- Code priority: 6 > 5 > 4 > 3 > 2 > 1.
- Verdict latency: the verdict pulses exactly 2 cycles after the cycle carrying /T/, or after the aborting word for codes 4/5/6.
- Code 6: the aborting start word simultaneously begins a new frame in PRE.
- Back-to-back frames: /T/ followed by a start word on the next cycle is legal. Verdicts may overlap processing of the next frame.
- PTP with P_PTP_MODE = 1: O_crc_compare_signal pulses with O_err_code = 0; O_crc_ok and O_crc_err stay 0; O_ptp_cnt increments.
- PTP with P_PTP_MODE = 0: normal ok/err verdict; O_ptp_cnt also increments.
- O_crc_ok and O_crc_err are never high together.
- Counters: increment at the verdict cycle and saturate at all-ones. I_cnt_clr wins over a coincident increment (result 0).
- Words in IDLE that are not start words are ignored.

Test Plan:
- Good 64-byte frame, /T/ in lane0 -> O_crc_ok pulses at T+2, O_err_code = 0, O_crc_out = frame FCS, O_ok_cnt = 1.
- Same frame with one payload byte flipped -> O_crc_err pulses at T+2, O_err_code = 1, O_err_cnt = 1.
- Frames of 64, 65, 66, 67 bytes (/T/ in lanes 0..3, valid FCS), sent back-to-back with no idle -> four O_crc_ok pulses, O_ok_cnt = 4.
- 60-byte frame with valid FCS -> code 2. 1523-byte frame with valid FCS -> code 3.
- Start, then a second start word 20 cycles later, then a good 64-byte frame -> code 6 for the first frame, then O_crc_ok for the second.
- P_PTP_MODE = 1 with I_ptp_flag = 1 at start, good frame -> compare pulse only, O_ptp_cnt = 1, O_ok_cnt = 0.
- Reset asserted mid-DATA -> no verdict, counters 0.
- I_cnt_clr coincident with an ok verdict -> O_ok_cnt = 0.
- Counters with P_CNT_W = 4 after 17 good frames -> O_ok_cnt = 15.
